// File: rtl/fifo_ctrl.sv
// fifo_ctrl: pointer/flag controller turning a dual-port RAM into a synchronous FIFO
module fifo_ctrl #(
  parameter int DATA_W = 10,
  parameter int ADDR_W = 3,
  parameter int AF_TH  = 6,
  parameter int AE_TH  = 2
) (
  input  logic              clk,
  input  logic              reset_L,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] data_in,
  input  logic [DATA_W-1:0] q_a,
  output logic [DATA_W-1:0] data_a,
  output logic [ADDR_W-1:0] addr_wa,
  output logic [ADDR_W-1:0] addr_ra,
  output logic              we_a,
  output logic              re_a,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [ADDR_W:0]   count,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic              error
);
  localparam int DEPTH = 2 ** ADDR_W;
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic push_ok, pop_ok;
  always_comb begin
    full         = count == (ADDR_W+1)'(DEPTH);
    empty        = count == '0;
    almost_full  = count >= (ADDR_W+1)'(AF_TH);
    almost_empty = count <= (ADDR_W+1)'(AE_TH);
    push_ok      = reset_L & push & ~full;
    pop_ok       = reset_L & pop & ~empty;
    we_a         = push_ok;
    re_a         = pop_ok;
    data_a       = data_in;
    addr_wa      = wr_ptr;
    addr_ra      = rd_ptr;
    data_out     = q_a;
  end
  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      valid_out <= 1'b0;
      error     <= 1'b0;
    end else begin
      wr_ptr    <= push_ok ? wr_ptr + 1'b1 : wr_ptr;
      rd_ptr    <= pop_ok ? rd_ptr + 1'b1 : rd_ptr;
      count     <= count + (ADDR_W+1)'(push_ok) - (ADDR_W+1)'(pop_ok);
      valid_out <= pop_ok;
      error     <= error | (push & full) | (pop & empty);
    end
  end
endmodule

// File: tb/tb_fifo_ctrl.sv
// tb_fifo_ctrl: randomized and directed check of fifo_ctrl against a queue model
module tb_fifo_ctrl;
  logic clk = 1'b0, reset_L = 1'b0, push = 1'b0, pop = 1'b0;
  logic [9:0] data_in = '0, q_a = '0, data_a, data_out;
  logic [2:0] addr_wa, addr_ra;
  logic [3:0] count;
  logic we_a, re_a, valid_out, full, empty, almost_full, almost_empty, error;
  logic [9:0] mem [8];
  int errors = 0, checks = 0;
  logic [9:0] mq [$];
  logic m_err = 1'b0, m_valid = 1'b0;
  logic [9:0] m_data = '0;
  int wn = 0, rn = 0;
  logic [9:0] pat [6] = '{10'h3FF, 10'h155, 10'h2AA, 10'h000, 10'h100, 10'h0F0};

  fifo_ctrl dut (
    .clk(clk), .reset_L(reset_L), .push(push), .pop(pop), .data_in(data_in),
    .q_a(q_a), .data_a(data_a), .addr_wa(addr_wa), .addr_ra(addr_ra),
    .we_a(we_a), .re_a(re_a), .data_out(data_out), .valid_out(valid_out),
    .count(count), .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .error(error)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we_a) mem[addr_wa] <= data_a;
    if (re_a) q_a <= mem[addr_ra];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_state();
    chk("count", count, mq.size());
    chk("full", full, mq.size() == 8);
    chk("empty", empty, mq.size() == 0);
    chk("almost_full", almost_full, mq.size() >= 6);
    chk("almost_empty", almost_empty, mq.size() <= 2);
    chk("error", error, m_err);
    chk("valid_out", valid_out, m_valid);
    if (m_valid) chk("data_out", data_out, m_data);
  endtask

  task automatic cycle(input logic p, input logic q, input logic [9:0] d);
    logic ap, aq;
    push = p;
    pop = q;
    data_in = d;
    ap = p && mq.size() < 8;
    aq = q && mq.size() > 0;
    #1;
    chk("we_a", we_a, ap);
    chk("re_a", re_a, aq);
    chk("addr_wa", addr_wa, wn % 8);
    chk("addr_ra", addr_ra, rn % 8);
    if (ap) chk("data_a", data_a, d);
    if ((p && mq.size() == 8) || (q && mq.size() == 0)) m_err = 1'b1;
    m_valid = aq;
    if (aq) begin
      m_data = mq.pop_front();
      rn++;
    end
    if (ap) begin
      mq.push_back(d);
      wn++;
    end
    @(posedge clk);
    @(negedge clk);
    check_state();
    push = 1'b0;
    pop = 1'b0;
  endtask

  task automatic do_reset();
    reset_L = 1'b0;
    push = 1'b1;
    pop = 1'b1;
    mq.delete();
    m_err = 1'b0;
    m_valid = 1'b0;
    wn = 0;
    rn = 0;
    #1;
    check_state();
    chk("we_a_rst", we_a, 0);
    chk("re_a_rst", re_a, 0);
    @(negedge clk);
    check_state();
    push = 1'b0;
    pop = 1'b0;
    reset_L = 1'b1;
    #1;
    check_state();
  endtask

  initial begin
    #2;
    do_reset();
    repeat (2) cycle(0, 0, 0);
    for (int i = 1; i <= 9; i++) cycle(1, 0, 10'(i));
    for (int i = 0; i < 9; i++) cycle(0, 1, 0);
    cycle(0, 0, 0);
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1, 0, 10'($urandom_range(0, 1023)));
    for (int i = 0; i < 5; i++) cycle(0, 1, 0);
    for (int i = 0; i < 6; i++) cycle(1, 0, pat[i]);
    for (int i = 0; i < 6; i++) cycle(0, 1, 0);
    for (int i = 0; i < 4; i++) cycle(1, 0, 10'($urandom_range(0, 1023)));
    cycle(1, 1, 10'h1A5);
    for (int i = 0; i < 4; i++) cycle(0, 1, 0);
    cycle(1, 1, 10'h055);
    cycle(0, 1, 0);
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1, 0, 10'($urandom_range(0, 1023)));
    cycle(1, 1, 10'h3C3);
    do_reset();
    for (int i = 0; i < 6; i++) cycle(1, 0, 10'($urandom_range(0, 1023)));
    cycle(0, 1, 0);
    chk("pre_rst_valid", valid_out, 1);
    #2;
    do_reset();
    @(negedge clk);
    cycle(1, 0, 10'h2D2);
    for (int i = 0; i < 400; i++) begin
      if (i % 97 == 96) do_reset();
      cycle(1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 50), 10'($urandom_range(0, 1023)));
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
